// File: rtl/xgbe_tx_pkg.sv
// Shared definitions for the 10GbE transmit framer.
//   ETH_HDR_BYTES    : Ethernet II header length (dst MAC, src MAC, EtherType)
//   HDR_SHIFT        : lane shift applied to the payload (header bytes past beat 0)
//   tx_state_e       : framer FSM states
//   keep_from_count  : byte count (0..8) -> contiguous tkeep mask from lane 0
//   count_from_keep  : contiguous tkeep mask -> byte count
//   lane_mask        : tkeep -> 64-bit data mask (one byte per keep bit)
package xgbe_tx_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int HDR_SHIFT     = ETH_HDR_BYTES - 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_PAD   = 2'd3
  } tx_state_e;

  function automatic logic [7:0] keep_from_count(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] count_from_keep(input logic [7:0] keep);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(keep[i]);
    end
    return c;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] keep);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/xgbe_tx_framer_byte_shift.sv
// Combinational 6-byte realigner. The six header/payload bytes carried over
// from the previous beat fill lanes 0-5, the current payload bytes 0-1 fill
// lanes 6-7, and payload bytes 2-7 become the next carry.
//   hold        in  48  carried bytes, byte i in [8i+7:8i]
//   data/keep   in  64/8 current payload beat
//   last        in  1   current beat is the payload's tlast beat
//   out_data    out 64  realigned beat, lanes past out_bytes forced to 0
//   out_bytes   out 4   valid bytes in out_data (8 unless the frame ends here)
//   next_hold   out 48  carry for the following beat
//   need_flush  out 1   last beat left bytes in the carry that need one more beat
//   flush_bytes out 4   number of carried bytes the flush beat will emit
module xgbe_tx_byte_shift
  import xgbe_tx_pkg::*;
(
  input  logic [47:0] hold,
  input  logic [63:0] data,
  input  logic [7:0]  keep,
  input  logic        last,
  output logic [63:0] out_data,
  output logic [3:0]  out_bytes,
  output logic [47:0] next_hold,
  output logic        need_flush,
  output logic [3:0]  flush_bytes
);

  // Payload bytes that fit in the current output beat after the shift.
  localparam logic [3:0] LANES_FREE = 4'(8 - HDR_SHIFT);

  logic [3:0] k;

  always_comb begin
    k           = count_from_keep(keep);
    need_flush  = last && (k > LANES_FREE);
    out_bytes   = (last && !need_flush) ? 4'(HDR_SHIFT) + k : 4'd8;
    flush_bytes = need_flush ? k - LANES_FREE : 4'd0;
    out_data    = {data[15:0], hold} & lane_mask(keep_from_count(out_bytes));
    next_hold   = data[63:16];
  end

endmodule

// File: rtl/xgbe_tx_framer.sv
// Transmit framer: prepends a 14-byte Ethernet II header to a headerless
// 64-bit AXI-Stream payload, realigns the payload by 6 bytes and zero-pads
// frames shorter than MIN_FRAME_BYTES. FCS is left to the MAC.
//   xgemac_clk_156            in   156.25 MHz MAC user clock
//   core_reset_n              in   asynchronous active-low reset
//   dst_mac_id / src_mac_id   in   48-bit MACs, [47:40] is wire byte 0
//   s_axis_t{data,keep,valid,last} / s_axis_tready   payload slave stream
//   m_axis_t{data,keep,valid,last} / m_axis_tready   framed master stream
//   frames_sent               out  completed output frames, wraps mod 2^32
module xgbe_tx_framer
  import xgbe_tx_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE       = 16'h88B5,
  parameter int          MIN_FRAME_BYTES = 60
) (
  input  logic        xgemac_clk_156,
  input  logic        core_reset_n,
  input  logic [47:0] dst_mac_id,
  input  logic [47:0] src_mac_id,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] frames_sent
);

  // A padded frame always ends on the beat that starts at PAD_LAST_START,
  // carrying PAD_LAST_BYTES bytes.
  localparam logic [13:0] PAD_LAST_START = 14'((MIN_FRAME_BYTES / 8) * 8);
  localparam logic [3:0]  PAD_LAST_BYTES = 4'(MIN_FRAME_BYTES - (MIN_FRAME_BYTES / 8) * 8);
  localparam logic [14:0] MIN_LEN        = 15'(MIN_FRAME_BYTES);
  localparam logic [13:0] CNT_MAX        = 14'h3FFF;

  tx_state_e   state, state_nxt;
  logic [47:0] hold, hold_nxt;
  logic [3:0]  flush_q, flush_nxt;
  logic [13:0] byte_cnt;

  logic        advance;
  logic        load;
  logic        is_end;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_last;
  logic [3:0]  o_bytes;
  logic [3:0]  cnt_add;

  logic [63:0] sh_data;
  logic [3:0]  sh_bytes;
  logic [47:0] sh_next_hold;
  logic        sh_need_flush;
  logic [3:0]  sh_flush_bytes;

  assign advance       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_DATA) && advance;

  xgbe_tx_byte_shift u_shift (
    .hold        (hold),
    .data        (s_axis_tdata),
    .keep        (s_axis_tkeep),
    .last        (s_axis_tlast),
    .out_data    (sh_data),
    .out_bytes   (sh_bytes),
    .next_hold   (sh_next_hold),
    .need_flush  (sh_need_flush),
    .flush_bytes (sh_flush_bytes)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below leaves a variable unassigned and infers a latch.
    state_nxt = state;
    hold_nxt  = hold;
    flush_nxt = flush_q;
    load      = 1'b0;
    is_end    = 1'b0;
    o_data    = '0;
    o_keep    = '0;
    o_last    = 1'b0;
    o_bytes   = '0;
    cnt_add   = '0;

    unique case (state)
      ST_IDLE: begin
        if (s_axis_tvalid && advance) begin
          load = 1'b1;
          for (int i = 0; i < 6; i++) begin
            o_data[8*i +: 8] = dst_mac_id[47-8*i -: 8];
          end
          o_data[63:48] = {src_mac_id[39:32], src_mac_id[47:40]};
          o_keep        = 8'hFF;
          for (int i = 0; i < 4; i++) begin
            hold_nxt[8*i +: 8] = src_mac_id[31-8*i -: 8];
          end
          hold_nxt[47:32] = {ETHERTYPE[7:0], ETHERTYPE[15:8]};
          state_nxt       = ST_DATA;
        end
      end

      ST_DATA: begin
        if (s_axis_tvalid && s_axis_tready) begin
          load     = 1'b1;
          hold_nxt = sh_next_hold;
          o_data   = sh_data;
          o_bytes  = sh_bytes;
          if (sh_need_flush) begin
            o_keep    = 8'hFF;
            cnt_add   = 4'd8;
            flush_nxt = sh_flush_bytes;
            state_nxt = ST_FLUSH;
          end else if (s_axis_tlast) begin
            is_end = 1'b1;
          end else begin
            o_keep  = 8'hFF;
            cnt_add = 4'd8;
          end
        end
      end

      ST_FLUSH: begin
        if (advance) begin
          load    = 1'b1;
          o_data  = {16'h0, hold} & lane_mask(keep_from_count(flush_q));
          o_bytes = flush_q;
          is_end  = 1'b1;
        end
      end

      ST_PAD: begin
        if (advance) begin
          load = 1'b1;
          if (byte_cnt == PAD_LAST_START) begin
            o_keep    = keep_from_count(PAD_LAST_BYTES);
            o_last    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            o_keep  = 8'hFF;
            cnt_add = 4'd8;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Last payload-carrying beat: either close the frame here or, for a runt,
    // emit a full zero-filled beat and continue in PAD. A runt whose data
    // already reaches the final pad beat closes right here.
    if (is_end) begin
      if (({1'b0, byte_cnt} + 15'(o_bytes)) < MIN_LEN) begin
        if (byte_cnt == PAD_LAST_START) begin
          o_keep    = keep_from_count(PAD_LAST_BYTES);
          o_last    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          o_keep    = 8'hFF;
          cnt_add   = 4'd8;
          state_nxt = ST_PAD;
        end
      end else begin
        o_keep    = keep_from_count(o_bytes);
        o_last    = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge xgemac_clk_156 or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state    <= ST_IDLE;
      // NOTE: the carry register is a plain register, not a memory, so it is
      // reset along with the rest to keep a truncated frame from leaking bytes.
      hold     <= '0;
      flush_q  <= '0;
      byte_cnt <= '0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      flush_q <= flush_nxt;
      if (load) begin
        if (state == ST_IDLE) begin
          byte_cnt <= 14'd8;
        end else if (byte_cnt > CNT_MAX - 14'(cnt_add)) begin
          byte_cnt <= CNT_MAX;
        end else begin
          byte_cnt <= byte_cnt + 14'(cnt_add);
        end
      end
    end
  end

  always_ff @(posedge xgemac_clk_156 or negedge core_reset_n) begin
    if (!core_reset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      frames_sent   <= '0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= o_data;
        m_axis_tkeep  <= o_keep;
        m_axis_tlast  <= o_last;
      end else if (advance) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        frames_sent <= frames_sent + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_xgbe_tx_framer.sv
// Scoreboard bench for xgbe_tx_framer. The driver pushes the expected framed
// beats (built as a flat byte list, padded, then cut into 8-byte beats) when a
// frame is issued; a negedge monitor pops and compares on every output
// handshake and also checks that a stalled beat stays put.
module tb_xgbe_tx_framer;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [47:0] dst_mac_id = '0;
  logic [47:0] src_mac_id = '0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [31:0] frames_sent;

  beat_t      exp_q[$];
  beat_t      obs_q[$];
  logic [7:0] pl[$];
  int         errors = 0;
  int         checks = 0;
  int         frames_issued = 0;
  bit         stress = 1'b0;
  bit         abort = 1'b0;

  always #5 clk = ~clk;

  xgbe_tx_framer dut (
    .xgemac_clk_156 (clk),
    .core_reset_n   (rst_n),
    .dst_mac_id     (dst_mac_id),
    .src_mac_id     (src_mac_id),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .frames_sent    (frames_sent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: frame = dst(6) + src(6) + EtherType high byte first + payload,
  // zero-padded to 60 bytes, then sliced into 8-byte beats.
  task automatic push_expected(input logic [47:0] dst, input logic [47:0] src);
    logic [7:0] fb[$];
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
    fb.push_back(8'h88);
    fb.push_back(8'hB5);
    foreach (pl[i]) fb.push_back(pl[i]);
    while (fb.size() < 60) fb.push_back(8'h00);
    for (int b = 0; b * 8 < fb.size(); b++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < fb.size()) begin
          e.data[8*l +: 8] = fb[b*8+l];
          e.keep[l]        = 1'b1;
        end
      end
      e.last = (b * 8 + 8 >= fb.size());
      exp_q.push_back(e);
    end
  endtask

  // Drives the payload in pl; starts and ends just after a rising edge.
  task automatic send_frame(input bit gaps);
    int len;
    len = pl.size();
    push_expected(dst_mac_id, src_mac_id);
    frames_issued++;
    for (int b = 0; b * 8 < len; b++) begin
      int          n;
      int          t;
      logic [63:0] d;
      n = (len - b * 8 > 8) ? 8 : len - b * 8;
      d = {$urandom, $urandom};
      for (int l = 0; l < n; l++) d[8*l +: 8] = pl[b*8+l];
      if (gaps && $urandom_range(0, 7) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axis_tdata  = d;
      s_axis_tkeep  = 8'((1 << n) - 1);
      s_axis_tlast  = (b * 8 + 8 >= len);
      s_axis_tvalid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_axis_tready && t < 4000 && !abort);
      if (abort) begin
        s_axis_tvalid = 1'b0;
        return;
      end
      if (!s_axis_tready) begin
        check("s_tready_timeout", 64'(s_axis_tready), 64'd1);
        abort         = 1'b1;
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (exp_q.size() != 0 && t < budget);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [47:0] dst, input logic [47:0] src);
    dst_mac_id = dst;
    src_mac_id = src;
    obs_q.delete();
    send_frame(1'b0);
    drain(2000);
  endtask

  function automatic logic [7:0] last_keep();
    if (obs_q.size() == 0) return 8'h00;
    return obs_q[obs_q.size()-1].keep;
  endfunction

  // Monitor: sampled on the falling edge, half a cycle from the active edge.
  beat_t mon_e;
  beat_t mon_prev;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", m_axis_tdata, mon_prev.data);
        check("stall_ctl", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep}),
              64'({1'b1, mon_prev.last, mon_prev.keep}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, mon_e.data);
          check("beat_ctl", 64'({m_axis_tkeep, m_axis_tlast}), 64'({mon_e.keep, mon_e.last}));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      mon_prev   = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    end
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_data", m_axis_tdata, 64'd0);
    check("rst_m_keep_last", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_frames_sent", 64'(frames_sent), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 64-byte incrementing payload
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    run_frame(48'h001122334455, 48'h00AABBCCDDEE);
    check("b64_beats", 64'(obs_q.size()), 64'd10);
    check("b64_beat0", obs_q[0].data, 64'hAA00554433221100);
    check("b64_last_keep", 64'(last_keep()), 64'h3F);
    check("b64_frames_sent", 64'(frames_sent), 64'd1);

    // 1-byte runt
    pl.delete();
    pl.push_back(8'h5A);
    run_frame(48'h020406080A0C, 48'h0E1012141618);
    check("b1_beats", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      check("b1_keep_last", 64'({obs_q[i].keep, obs_q[i].last}),
            (i < 7) ? 64'h1FE : 64'h01F);
    end
    if (obs_q.size() > 1) check("b1_byte14", 64'(obs_q[1].data[55:48]), 64'h5A);

    // 46 bytes: exactly 60, no pad; 47 bytes: 61
    pl.delete();
    for (int i = 0; i < 46; i++) pl.push_back(8'($urandom));
    run_frame(48'h112233445566, 48'h665544332211);
    check("b46_beats", 64'(obs_q.size()), 64'd8);
    check("b46_last_keep", 64'(last_keep()), 64'h0F);
    pl.delete();
    for (int i = 0; i < 47; i++) pl.push_back(8'($urandom));
    run_frame(48'h112233445566, 48'h665544332211);
    check("b47_beats", 64'(obs_q.size()), 64'd8);
    check("b47_last_keep", 64'(last_keep()), 64'h1F);

    // 131 bytes: flush beat with one byte
    pl.delete();
    for (int i = 0; i < 131; i++) pl.push_back(8'($urandom));
    run_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6);
    check("b131_beats", 64'(obs_q.size()), 64'd19);
    check("b131_last_keep", 64'(last_keep()), 64'h01);
    total = 0;
    foreach (obs_q[i]) total += $countones(obs_q[i].keep);
    check("b131_total_bytes", 64'(total), 64'd145);

    // Stress: back-to-back random frames with random backpressure
    stress = 1'b1;
    for (int f = 0; f < 200 && !abort; f++) begin
      pl.delete();
      for (int i = $urandom_range(1, 1500); i > 0; i--) pl.push_back(8'($urandom));
      dst_mac_id = {$urandom, $urandom};
      src_mac_id = {$urandom, $urandom};
      send_frame(1'b1);
    end
    drain(5000);
    stress = 1'b0;
    check("stress_frames_sent", 64'(frames_sent), 64'(frames_issued));

    // Reset during output beat 3 of a 200-byte frame
    pl.delete();
    for (int i = 0; i < 200; i++) pl.push_back(8'($urandom));
    dst_mac_id = 48'hC0C1C2C3C4C5;
    src_mac_id = 48'hD0D1D2D3D4D5;
    obs_q.delete();
    fork
      send_frame(1'b0);
      begin
        int t;
        t = 0;
        do begin
          @(posedge clk);
          #2;
          t++;
        end while (!(obs_q.size() == 3 && m_axis_tvalid) && t < 1000);
        check("rst_reached_beat3", 64'(obs_q.size()), 64'd3);
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check("mrst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("mrst_m_data", m_axis_tdata, 64'd0);
        check("mrst_m_keep_last", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
        check("mrst_s_tready", 64'(s_axis_tready), 64'd0);
        check("mrst_frames_sent", 64'(frames_sent), 64'd0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    frames_issued = 0;
    abort = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    run_frame(48'h001122334455, 48'h00AABBCCDDEE);
    check("post_rst_beats", 64'(obs_q.size()), 64'd10);
    check("post_rst_frames_sent", 64'(frames_sent), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
